leaf_user_adapter: RTL and testbench



---
 rtl/leaf_user_adapter.sv | 121 ++++++++++++
 tb/tb_leaf_user_adapter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_adapter.sv
// Stream adapter between the leaf interface user ports and an HLS operator's ap_vld/ap_ack ports.
// Every channel has its own elastic FIFO, and an ap_start run-control FSM counts operator completions.
module leaf_user_adapter #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 2,
    parameter int NUM_OUT_PORTS   = 2,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                                    clk_user,
    input  logic                                    reset,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    op_in_data,
    output logic [NUM_IN_PORTS-1:0]                 op_in_vld,
    input  logic [NUM_IN_PORTS-1:0]                 op_in_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   op_out_data,
    input  logic [NUM_OUT_PORTS-1:0]                op_out_vld,
    output logic [NUM_OUT_PORTS-1:0]                op_out_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    run_en,
    output logic                                    ap_start,
    input  logic                                    ap_done,
    output logic [15:0]                             done_count,
    output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]   fifo_nonempty
);

    localparam int NCH   = NUM_IN_PORTS + NUM_OUT_PORTS;
    localparam int AW    = FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Channels 0..NUM_IN_PORTS-1 carry interface->operator traffic; the rest carry operator->interface.
    logic [NCH-1:0]              push_vld;
    logic [NCH-1:0]              push_rdy;
    logic [NCH-1:0]              pop_vld;
    logic [NCH-1:0]              pop_ack;
    logic [NCH*PAYLOAD_BITS-1:0] push_data;
    logic [NCH*PAYLOAD_BITS-1:0] pop_data;

    assign push_vld  = {op_out_vld, vld_interface2user};
    assign push_data = {op_out_data, dout_leaf_interface2user};
    assign pop_ack   = {ack_interface2user, op_in_ack};

    assign ack_user2interface      = push_rdy[NUM_IN_PORTS-1:0];
    assign op_out_ack              = push_rdy[NCH-1:NUM_IN_PORTS];
    assign op_in_vld               = pop_vld[NUM_IN_PORTS-1:0];
    assign vld_user2interface      = pop_vld[NCH-1:NUM_IN_PORTS];
    assign op_in_data              = pop_data[NUM_IN_PORTS*PAYLOAD_BITS-1:0];
    assign din_leaf_user2interface = pop_data[NCH*PAYLOAD_BITS-1:NUM_IN_PORTS*PAYLOAD_BITS];
    assign fifo_nonempty           = pop_vld;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PAYLOAD_BITS-1:0] mem [DEPTH];
        logic [AW-1:0]           wr_ptr;
        logic [AW-1:0]           rd_ptr;
        logic [AW:0]             count;
        logic                    push;
        logic                    pop;

        // Full blocks pushes even when a pop happens in the same cycle, so ack depends only on count.
        assign push_rdy[c] = (count < CNT_FULL);
        assign pop_vld[c]  = (count != '0);
        assign push        = push_vld[c] & push_rdy[c];
        assign pop         = pop_vld[c] & pop_ack[c];
        assign pop_data[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr];

        always_ff @(posedge clk_user) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end
        end

        always_ff @(posedge clk_user) begin
            if (push) mem[wr_ptr] <= push_data[c*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    logic [1:0] state;

    assign ap_start = (state == RUN);

    // Completions are counted in every state, including stray pulses seen while idle.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            state      <= IDLE;
            done_count <= '0;
        end else begin
            if (ap_done) done_count <= sat_inc16(done_count);
            case (state)
                IDLE: if (run_en) state <= RUN;
                RUN: begin
                    if (ap_done)      state <= run_en ? RUN : IDLE;
                    else if (!run_en) state <= STOP;
                end
                STOP: if (ap_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_user_adapter.sv
// Bench for leaf_user_adapter: directed scenarios plus randomized traffic against per-channel queue models.
module tb_leaf_user_adapter;

    localparam int P   = 32;
    localparam int NI  = 2;
    localparam int NO  = 2;
    localparam int NCH = NI + NO;
    localparam int D   = 8;

    logic                clk_user = 1'b0;
    logic                reset;
    logic [NI*P-1:0]     dout_leaf_interface2user;
    logic [NI-1:0]       vld_interface2user;
    logic [NI-1:0]       ack_user2interface;
    logic [NI*P-1:0]     op_in_data;
    logic [NI-1:0]       op_in_vld;
    logic [NI-1:0]       op_in_ack;
    logic [NO*P-1:0]     op_out_data;
    logic [NO-1:0]       op_out_vld;
    logic [NO-1:0]       op_out_ack;
    logic [NO*P-1:0]     din_leaf_user2interface;
    logic [NO-1:0]       vld_user2interface;
    logic [NO-1:0]       ack_interface2user;
    logic                run_en;
    logic                ap_start;
    logic                ap_done;
    logic [15:0]         done_count;
    logic [NCH-1:0]      fifo_nonempty;

    always #5 clk_user = ~clk_user;

    leaf_user_adapter #(
        .PAYLOAD_BITS(P), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH_BITS(3)
    ) dut (
        .clk_user(clk_user),
        .reset(reset),
        .dout_leaf_interface2user(dout_leaf_interface2user),
        .vld_interface2user(vld_interface2user),
        .ack_user2interface(ack_user2interface),
        .op_in_data(op_in_data),
        .op_in_vld(op_in_vld),
        .op_in_ack(op_in_ack),
        .op_out_data(op_out_data),
        .op_out_vld(op_out_vld),
        .op_out_ack(op_out_ack),
        .din_leaf_user2interface(din_leaf_user2interface),
        .vld_user2interface(vld_user2interface),
        .ack_interface2user(ack_interface2user),
        .run_en(run_en),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .done_count(done_count),
        .fifo_nonempty(fifo_nonempty)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each channel is an ordered queue of capacity D; done count is a plain integer.
    logic [31:0] q [NCH][$];
    logic        pv [NCH];
    logic [31:0] pd [NCH];
    logic        pa [NCH];
    bit          pushed [NCH];
    int          m_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic dut_vld(input int c);
        return (c < NI) ? op_in_vld[c] : vld_user2interface[c-NI];
    endfunction

    function automatic logic dut_ack(input int c);
        return (c < NI) ? ack_user2interface[c] : op_out_ack[c-NI];
    endfunction

    function automatic logic [31:0] dut_data(input int c);
        return (c < NI) ? op_in_data[c*P +: P] : din_leaf_user2interface[(c-NI)*P +: P];
    endfunction

    task automatic apply();
        for (int c = 0; c < NCH; c++) begin
            if (c < NI) begin
                vld_interface2user[c]          = pv[c];
                dout_leaf_interface2user[c*P +: P] = pd[c];
                op_in_ack[c]                   = pa[c];
            end else begin
                op_out_vld[c-NI]               = pv[c];
                op_out_data[(c-NI)*P +: P]     = pd[c];
                ack_interface2user[c-NI]       = pa[c];
            end
        end
    endtask

    // Called at a falling edge with stimulus arrays set; checks outputs, then advances one clock.
    task automatic step();
        bit popped [NCH];
        int exp_done;
        apply();
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("vld ch%0d", c), 64'(dut_vld(c)), 64'(q[c].size() != 0));
            chk($sformatf("ack ch%0d", c), 64'(dut_ack(c)), 64'(q[c].size() < D));
            chk($sformatf("nonempty ch%0d", c), 64'(fifo_nonempty[c]), 64'(q[c].size() != 0));
            if (q[c].size() != 0)
                chk($sformatf("data ch%0d", c), 64'(dut_data(c)), 64'(q[c][0]));
        end
        exp_done = (m_done > 65535) ? 65535 : m_done;
        chk("done_count", 64'(done_count), 64'(exp_done));
        for (int c = 0; c < NCH; c++) begin
            pushed[c] = pv[c] && (q[c].size() < D);
            popped[c] = pa[c] && (q[c].size() != 0);
        end
        @(posedge clk_user);
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                q[c].delete();
                pushed[c] = 1'b0;
            end
            m_done = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (popped[c]) void'(q[c].pop_front());
                if (pushed[c]) q[c].push_back(pd[c]);
            end
            if (ap_done) m_done++;
        end
        @(negedge clk_user);
    endtask

    task automatic pulse(input int n);
        ap_done = 1'b1;
        repeat (n) @(posedge clk_user);
        @(negedge clk_user);
        ap_done = 1'b0;
        m_done += n;
    endtask

    initial begin
        int nxt;
        int n2;
        int n3;
        int budget;
        reset = 1'b1; run_en = 1'b0; ap_done = 1'b0;
        for (int c = 0; c < NCH; c++) begin pv[c] = 1'b0; pd[c] = '0; pa[c] = 1'b0; end
        apply();
        repeat (2) @(posedge clk_user);
        @(negedge clk_user);
        step();
        chk("ap_start reset", 64'(ap_start), 64'd0);
        reset = 1'b0;
        step();

        // Run control
        run_en = 1'b1;
        chk("ap_start before edge", 64'(ap_start), 64'd0);
        step();
        chk("ap_start after run_en", 64'(ap_start), 64'd1);
        step();
        chk("ap_start held run", 64'(ap_start), 64'd1);
        run_en = 1'b0;
        step();
        chk("ap_start stop", 64'(ap_start), 64'd0);
        run_en = 1'b1;
        step();
        chk("stop ignores run_en", 64'(ap_start), 64'd0);
        run_en = 1'b0; ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        chk("done_count first", 64'(done_count), 64'd1);
        chk("ap_start idle after done", 64'(ap_start), 64'd0);
        run_en = 1'b1;
        step();
        chk("idle restarts", 64'(ap_start), 64'd1);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        chk("free-run restart", 64'(ap_start), 64'd1);
        ap_done = 1'b1; run_en = 1'b0;
        step();
        ap_done = 1'b0;
        chk("run done to idle", 64'(ap_start), 64'd0);
        run_en = 1'b1;
        step();
        chk("idle again restarts", 64'(ap_start), 64'd1);
        run_en = 1'b0;
        step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        chk("stop done idle", 64'(ap_start), 64'd0);

        // Single word on input channel 1
        for (int c = 0; c < NCH; c++) pa[c] = 1'b1;
        pv[1] = 1'b1; pd[1] = 32'hDEADBEEF;
        step();
        pv[1] = 1'b0;
        chk("single vld t+1", 64'(op_in_vld), 64'b10);
        chk("single data t+1", 64'(op_in_data[63:32]), 64'hDEADBEEF);
        step();
        chk("single vld gone", 64'(op_in_vld), 64'b00);
        step();

        // Fill input channel 0 with the operator stalled, then drain
        pa[0] = 1'b0; pv[0] = 1'b1; nxt = 0;
        for (int i = 0; i < 12; i++) begin
            pd[0] = nxt;
            step();
            if (pushed[0]) nxt++;
        end
        chk("fill accepted", 64'(nxt), 64'd8);
        chk("fill ack low", 64'(ack_user2interface[0]), 64'd0);
        pa[0] = 1'b1;
        budget = 0;
        while ((nxt < 10 || q[0].size() != 0) && budget < 40) begin
            pv[0] = (nxt < 10);
            pd[0] = nxt;
            step();
            if (pushed[0]) nxt++;
            budget++;
        end
        pv[0] = 1'b0;
        chk("fill drain in budget", 64'(budget < 40), 64'd1);
        step();

        // Steady push+pop at occupancy 4 on output channel 0, across pointer wrap
        pa[2] = 1'b0; pv[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin pd[2] = 32'h100 + i; step(); end
        pa[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin pd[2] = 32'h104 + i; step(); end
        pv[2] = 1'b0;
        repeat (5) step();

        // Backpressure on output channel 1 only
        pa[2] = 1'b1; pa[3] = 1'b0; pv[2] = 1'b1; pv[3] = 1'b1;
        n2 = 0; n3 = 0;
        for (int i = 0; i < 12; i++) begin
            pd[2] = 32'h2000 + n2; pd[3] = 32'h3000 + n3;
            if (vld_user2interface[0] && ack_interface2user[0]) begin end
            step();
            if (pushed[2]) n2++;
            if (pushed[3]) n3++;
        end
        chk("ch0 out full rate", 64'(n2), 64'd12);
        chk("ch1 out blocked", 64'(n3), 64'd8);
        chk("ch0 out still vld", 64'(vld_user2interface[0]), 64'd1);
        pv[2] = 1'b0; pv[3] = 1'b0; pa[3] = 1'b1;
        repeat (10) step();

        // Randomized traffic on all channels
        for (int c = 0; c < NCH; c++) pushed[c] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pv[c] || pushed[c]) begin
                    pv[c] = 1'($urandom_range(0, 1));
                    pd[c] = $urandom;
                end
                pa[c] = ($urandom_range(0, 3) != 0);
            end
            ap_done = ($urandom_range(0, 7) == 0);
            step();
        end
        ap_done = 1'b0;
        for (int c = 0; c < NCH; c++) begin pv[c] = 1'b0; pa[c] = 1'b1; end
        repeat (10) step();

        // done_count saturation
        pulse(65534 - m_done);
        chk("done_count FFFE", 64'(done_count), 64'hFFFE);
        pulse(1);
        chk("done_count FFFF", 64'(done_count), 64'hFFFF);
        pulse(70000 - m_done);
        chk("done_count saturated", 64'(done_count), 64'hFFFF);
        step();

        // Reset with five words buffered and the operator running
        pa[0] = 1'b0; pv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin pd[0] = 32'h500 + i; step(); end
        pv[0] = 1'b0; run_en = 1'b1;
        step();
        chk("running before reset", 64'(ap_start), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; run_en = 1'b0;
        chk("reset vld", 64'(op_in_vld), 64'd0);
        chk("reset nonempty", 64'(fifo_nonempty), 64'd0);
        chk("reset done_count", 64'(done_count), 64'd0);
        chk("reset ap_start", 64'(ap_start), 64'd0);
        step();
        chk("idle after reset", 64'(ap_start), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
